kmeans_centroid_update_k4_d4: RTL and testbench

KMEANS_CENTROID_UPDATE_K4_D4 -- requirements
Module: kmeans_centroid_update_k4_d4

---
 rtl/kmeans_pkg.sv | 21 ++
 rtl/kmeans_seq_divider.sv | 66 ++++++
 rtl/kmeans_centroid_update_k4_d4.sv | 190 +++++++++++++++++++
 tb/tb_kmeans_centroid_update_k4_d4.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared constants, FSM encoding and width helpers for the k-means centroid update block.
package kmeans_pkg;

  localparam int NUM_CLUSTERS = 4;
  localparam int NUM_DIMS     = 4;
  localparam int DIM_W        = $clog2(NUM_DIMS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DIV,
    ST_EMIT,
    ST_DONE
  } state_t;

  // A sum must hold up to (2^count_width - 1) full-scale points without wrapping.
  function automatic int sum_width(input int data_width, input int count_width);
    return data_width + count_width;
  endfunction

endpackage

// File: rtl/kmeans_seq_divider.sv
// Unsigned restoring divider: one load cycle followed by one iteration per dividend bit.
module kmeans_seq_divider #(
  parameter int dividend_width = 32,
  parameter int divisor_width  = 16,
  parameter int quotient_width = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [quotient_width-1:0] quotient
);

  localparam int ITER_W = $clog2(dividend_width + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(dividend_width - 1);

  logic [divisor_width-1:0]  rem;
  logic [divisor_width-1:0]  dsr;
  logic [dividend_width-1:0] quo;
  logic [ITER_W-1:0]         iter;
  logic [divisor_width:0]    shifted;
  logic [divisor_width+1:0]  trial;
  logic                      fits;

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  always_comb begin
    shifted = {rem, quo[dividend_width-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr};
    fits    = ~trial[divisor_width+1];
  end

  // Load on start when idle, then iterate; done pulses with the final quotient bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem  <= '0;
      dsr  <= '0;
      quo  <= '0;
      iter <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo  <= dividend;
        dsr  <= divisor;
        rem  <= '0;
        iter <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= fits ? trial[divisor_width-1:0] : shifted[divisor_width-1:0];
        quo  <= {quo[dividend_width-2:0], fits};
        iter <= iter + 1'b1;
        if (iter == LAST_ITER) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[quotient_width-1:0];

endmodule

// File: rtl/kmeans_centroid_update_k4_d4.sv
// Accumulates classified points per cluster, then divides each sum by its member
// count with one shared sequential divider and streams out the new centroids.
module kmeans_centroid_update_k4_d4
  import kmeans_pkg::*;
#(
  parameter int input_data_width  = 16,
  parameter int centroid_id_width = 2,
  parameter int count_width       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [input_data_width-1:0]  input_data0,
  input  logic [input_data_width-1:0]  input_data1,
  input  logic [input_data_width-1:0]  input_data2,
  input  logic [input_data_width-1:0]  input_data3,
  input  logic [centroid_id_width-1:0] selected_centroid,
  input  logic                         flush,
  output logic                         centroid_valid,
  input  logic                         centroid_ready,
  output logic [centroid_id_width-1:0] centroid_id,
  output logic [input_data_width-1:0]  centroid_d0,
  output logic [input_data_width-1:0]  centroid_d1,
  output logic [input_data_width-1:0]  centroid_d2,
  output logic [input_data_width-1:0]  centroid_d3,
  output logic                         centroid_empty,
  output logic                         overflow,
  output logic                         done
);

  localparam int SUM_W = sum_width(input_data_width, count_width);
  localparam logic [centroid_id_width-1:0] LAST_K = centroid_id_width'(NUM_CLUSTERS - 1);
  localparam logic [DIM_W-1:0]             LAST_D = DIM_W'(NUM_DIMS - 1);

  state_t                        state;
  logic [SUM_W-1:0]              sum   [NUM_CLUSTERS][NUM_DIMS];
  logic [count_width-1:0]        count [NUM_CLUSTERS];
  logic [input_data_width-1:0]   res   [NUM_DIMS];
  logic [input_data_width-1:0]   point [NUM_DIMS];
  logic [centroid_id_width-1:0]  k;
  logic [DIM_W-1:0]              issue_d;
  logic [DIM_W-1:0]              wr_d;
  logic                          all_issued;
  logic                          div_start;
  logic                          div_busy;
  logic                          div_done;
  logic [SUM_W-1:0]              div_dividend;
  logic [count_width-1:0]        div_divisor;
  logic [input_data_width-1:0]   div_quotient;
  logic                          cluster_empty;

  // A counter at all-ones is full; further members for that cluster are dropped.
  function automatic logic count_full(input logic [count_width-1:0] c);
    return &c;
  endfunction

  // Empty clusters report a zero mean regardless of what the divider produced.
  function automatic logic [input_data_width-1:0] mean_of(
    input logic [input_data_width-1:0] q,
    input logic                        is_empty
  );
    return is_empty ? '0 : q;
  endfunction

  assign point[0] = input_data0;
  assign point[1] = input_data1;
  assign point[2] = input_data2;
  assign point[3] = input_data3;

  // Divisions are issued back to back: a new one starts the cycle after the previous finishes.
  assign div_start     = (state == ST_DIV) && !div_busy && !all_issued;
  assign div_dividend  = sum[k][issue_d];
  assign div_divisor   = count[k];
  assign cluster_empty = (count[k] == '0);

  kmeans_seq_divider #(
    .dividend_width (SUM_W),
    .divisor_width  (count_width),
    .quotient_width (input_data_width)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Pass control FSM with accumulators and registered centroid outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b0;
      centroid_valid <= 1'b0;
      centroid_empty <= 1'b0;
      centroid_id    <= '0;
      centroid_d0    <= '0;
      centroid_d1    <= '0;
      centroid_d2    <= '0;
      centroid_d3    <= '0;
      overflow       <= 1'b0;
      done           <= 1'b0;
      k              <= '0;
      issue_d        <= '0;
      wr_d           <= '0;
      all_issued     <= 1'b0;
      for (int c = 0; c < NUM_CLUSTERS; c++) begin
        count[c] <= '0;
        for (int n = 0; n < NUM_DIMS; n++) sum[c][n] <= '0;
      end
      for (int n = 0; n < NUM_DIMS; n++) res[n] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
              count[c] <= '0;
              for (int n = 0; n < NUM_DIMS; n++) sum[c][n] <= '0;
            end
            overflow <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            if (count_full(count[selected_centroid])) begin
              overflow <= 1'b1;
            end else begin
              count[selected_centroid] <= count[selected_centroid] + 1'b1;
              for (int n = 0; n < NUM_DIMS; n++)
                sum[selected_centroid][n] <= sum[selected_centroid][n] + SUM_W'(point[n]);
            end
          end
          if (flush) begin
            in_ready   <= 1'b0;
            k          <= '0;
            issue_d    <= '0;
            wr_d       <= '0;
            all_issued <= 1'b0;
            state      <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_start) begin
            issue_d <= issue_d + 1'b1;
            if (issue_d == LAST_D) all_issued <= 1'b1;
          end
          if (div_done) begin
            res[wr_d] <= mean_of(div_quotient, cluster_empty);
            wr_d      <= wr_d + 1'b1;
            if (wr_d == LAST_D) begin
              centroid_valid <= 1'b1;
              centroid_id    <= k;
              centroid_empty <= cluster_empty;
              centroid_d0    <= res[0];
              centroid_d1    <= res[1];
              centroid_d2    <= res[2];
              centroid_d3    <= mean_of(div_quotient, cluster_empty);
              state          <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (centroid_ready) begin
            centroid_valid <= 1'b0;
            if (k == LAST_K) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              k          <= k + 1'b1;
              issue_d    <= '0;
              wr_d       <= '0;
              all_issued <= 1'b0;
              state      <= ST_DIV;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_update_k4_d4.sv
// Directed bench for the k-means centroid update block.
module tb_kmeans_centroid_update_k4_d4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] input_data0 = '0;
  logic [15:0] input_data1 = '0;
  logic [15:0] input_data2 = '0;
  logic [15:0] input_data3 = '0;
  logic [1:0]  selected_centroid = '0;
  logic        flush = 1'b0;
  logic        centroid_valid;
  logic        centroid_ready = 1'b0;
  logic [1:0]  centroid_id;
  logic [15:0] centroid_d0;
  logic [15:0] centroid_d1;
  logic [15:0] centroid_d2;
  logic [15:0] centroid_d3;
  logic        centroid_empty;
  logic        overflow;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_d [4][4];
  logic        exp_e [4];

  kmeans_centroid_update_k4_d4 dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .input_data0       (input_data0),
    .input_data1       (input_data1),
    .input_data2       (input_data2),
    .input_data3       (input_data3),
    .selected_centroid (selected_centroid),
    .flush             (flush),
    .centroid_valid    (centroid_valid),
    .centroid_ready    (centroid_ready),
    .centroid_id       (centroid_id),
    .centroid_d0       (centroid_d0),
    .centroid_d1       (centroid_d1),
    .centroid_d2       (centroid_d2),
    .centroid_d3       (centroid_d3),
    .centroid_empty    (centroid_empty),
    .overflow          (overflow),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 4; c++) begin
      exp_e[c] = 1'b1;
      for (int n = 0; n < 4; n++) exp_d[c][n] = '0;
    end
  endtask

  task automatic set_exp(input int c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e, input logic [15:0] f);
    exp_e[c]    = 1'b0;
    exp_d[c][0] = a;
    exp_d[c][1] = b;
    exp_d[c][2] = e;
    exp_d[c][3] = f;
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    check("acc_in_ready", {63'd0, in_ready}, 64'd1);
    check("acc_overflow_clear", {63'd0, overflow}, 64'd0);
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] e, input logic [15:0] f, input logic fl);
    in_valid          = 1'b1;
    selected_centroid = c;
    input_data0       = a;
    input_data1       = b;
    input_data2       = e;
    input_data3       = f;
    flush             = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!centroid_valid && n < 400) begin
      step();
      n++;
    end
    check("valid_timeout", {63'd0, centroid_valid}, 64'd1);
  endtask

  // Called right after the flush edge; hold > 0 keeps centroid_ready low that many cycles.
  task automatic collect(input string name, input int hold);
    int n;
    for (int c = 0; c < 4; c++) begin
      centroid_ready = (hold == 0);
      wait_valid(n);
      if (c == 0) check({name, "_first_valid_latency"}, n, 133);
      if (hold > 0) begin
        repeat (hold) step();
        check({name, "_hold_valid"}, {63'd0, centroid_valid}, 64'd1);
        centroid_ready = 1'b1;
      end
      check({name, "_id"}, centroid_id, c);
      check({name, "_empty"}, {63'd0, centroid_empty}, {63'd0, exp_e[c]});
      check({name, "_d0"}, centroid_d0, exp_d[c][0]);
      check({name, "_d1"}, centroid_d1, exp_d[c][1]);
      check({name, "_d2"}, centroid_d2, exp_d[c][2]);
      check({name, "_d3"}, centroid_d3, exp_d[c][3]);
      check({name, "_emit_in_ready"}, {63'd0, in_ready}, 64'd0);
      step();
      centroid_ready = 1'b0;
      if (c < 3) begin
        check({name, "_valid_drop"}, {63'd0, centroid_valid}, 64'd0);
        check({name, "_no_early_done"}, {63'd0, done}, 64'd0);
      end else begin
        check({name, "_done_pulse"}, {63'd0, done}, 64'd1);
      end
    end
    step();
    check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    check({name, "_idle_valid"}, {63'd0, centroid_valid}, 64'd0);
  endtask

  initial begin
    logic seen;
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_valid", {63'd0, centroid_valid}, 64'd0);
    check("rst_empty", {63'd0, centroid_empty}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_id", centroid_id, 0);
    check("rst_d0", centroid_d0, 0);
    check("rst_d3", centroid_d3, 0);

    // Flush in IDLE has no effect
    do_flush();
    repeat (3) step();
    check("idle_flush_in_ready", {63'd0, in_ready}, 64'd0);
    check("idle_flush_valid", {63'd0, centroid_valid}, 64'd0);

    // Test 1: four points to cluster 1
    start_pass();
    send(2'd1, 16'd10, 16'd8, 16'd8, 16'd8, 1'b0);
    send(2'd1, 16'd20, 16'd8, 16'd8, 16'd8, 1'b0);
    send(2'd1, 16'd30, 16'd8, 16'd8, 16'd8, 1'b0);
    send(2'd1, 16'd40, 16'd8, 16'd8, 16'd8, 1'b0);
    do_flush();
    check("t1_div_in_ready", {63'd0, in_ready}, 64'd0);
    clear_exp();
    set_exp(1, 16'd25, 16'd8, 16'd8, 16'd8);
    collect("t1", 0);

    // Test 2: the point that arrives with flush is counted
    start_pass();
    send(2'd2, 16'd7, 16'd7, 16'd7, 16'd7, 1'b1);
    clear_exp();
    set_exp(2, 16'd7, 16'd7, 16'd7, 16'd7);
    collect("t2", 0);

    // Test 3: truncating division, wide sums, start ignored mid-pass
    start_pass();
    send(2'd3, 16'd3, 16'd0, 16'd100, 16'hFFFF, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    send(2'd3, 16'd3, 16'd0, 16'd100, 16'hFFFF, 1'b0);
    send(2'd3, 16'd4, 16'd2, 16'd101, 16'hFFFF, 1'b0);
    send(2'd0, 16'h0001, 16'h0002, 16'h0003, 16'hABCD, 1'b0);
    do_flush();
    clear_exp();
    set_exp(0, 16'h0001, 16'h0002, 16'h0003, 16'hABCD);
    set_exp(3, 16'd3, 16'd0, 16'd100, 16'hFFFF);
    collect("t3", 0);

    // Test 4: consumer stalls 20 cycles on every centroid
    start_pass();
    clear_exp();
    for (int c = 0; c < 4; c++) begin
      send(2'(c), 16'(16*c+1), 16'(16*c+2), 16'(16*c+3), 16'(16*c+4), 1'b0);
      send(2'(c), 16'(16*c+3), 16'(16*c+4), 16'(16*c+5), 16'(16*c+6), 1'b0);
      set_exp(c, 16'(16*c+2), 16'(16*c+3), 16'(16*c+4), 16'(16*c+5));
    end
    do_flush();
    collect("t4", 20);

    // Test 5: reset in the middle of DIV aborts the pass
    start_pass();
    send(2'd1, 16'd50, 16'd60, 16'd70, 16'd80, 1'b0);
    do_flush();
    repeat (50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("t5_rst_valid", {63'd0, centroid_valid}, 64'd0);
    check("t5_rst_done", {63'd0, done}, 64'd0);
    check("t5_rst_id", centroid_id, 0);
    check("t5_rst_d0", centroid_d0, 0);
    check("t5_rst_overflow", {63'd0, overflow}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done || centroid_valid) seen = 1'b1;
    end
    check("t5_no_done_after_abort", {63'd0, seen}, 64'd0);
    start_pass();
    send(2'd0, 16'd100, 16'd1, 16'd0, 16'hFFFF, 1'b0);
    send(2'd0, 16'd200, 16'd2, 16'd0, 16'hFFFF, 1'b0);
    send(2'd3, 16'd9, 16'd9, 16'd9, 16'd9, 1'b0);
    do_flush();
    clear_exp();
    set_exp(0, 16'd150, 16'd1, 16'd0, 16'hFFFF);
    set_exp(3, 16'd9, 16'd9, 16'd9, 16'd9);
    collect("t5", 0);

    // Test 6: counter saturation on cluster 0
    start_pass();
    in_valid          = 1'b1;
    selected_centroid = 2'd0;
    input_data0       = 16'hFFFF;
    input_data1       = 16'hFFFF;
    input_data2       = 16'hFFFF;
    input_data3       = 16'hFFFF;
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) check("t6_overflow_before_last", {63'd0, overflow}, 64'd0);
      step();
    end
    in_valid = 1'b0;
    check("t6_overflow_set", {63'd0, overflow}, 64'd1);
    do_flush();
    check("t6_overflow_sticky", {63'd0, overflow}, 64'd1);
    clear_exp();
    set_exp(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    collect("t6", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
